sp_tc_tile_sequencer: RTL

//  Sequences one sparse tensor-core tile job as a run of K-steps. Per step: pulses core start, streams A/B/weight-index/C

---
 rtl/sp_tc_pkg.sv | 26 ++
 rtl/sp_tc_addr_gen.sv | 25 ++
 rtl/sp_tc_tile_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sp_tc_pkg.sv
// Shared types and defaults for the sparse tensor-core tile sequencer.
package sp_tc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_FETCH,
    S_FETCH,
    S_FDONE,
    S_WAIT_COMP,
    S_WAIT_WB,
    S_RESULT
  } state_t;

  localparam int FETCH_BEATS_DEF = 2;
  localparam int WDOG_CYCLES_DEF = 256;

  function automatic int wdog_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sp_tc_addr_gen.sv
// A and B/index read addresses: base + k*FETCH_BEATS + beat, wrapping mod 2^ADDR_W.
module sp_tc_addr_gen
  import sp_tc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int KSTEP_W     = 8,
  parameter int FETCH_BEATS = FETCH_BEATS_DEF,
  parameter int BEAT_W      = beat_width(FETCH_BEATS)
) (
  input  logic [ADDR_W-1:0]  a_base,
  input  logic [ADDR_W-1:0]  b_base,
  input  logic [KSTEP_W-1:0] k,
  input  logic [BEAT_W-1:0]  beat,
  output logic [ADDR_W-1:0]  a_addr,
  output logic [ADDR_W-1:0]  b_addr
);

  logic [ADDR_W-1:0] offset;

  // Truncating the operands first is exact because the result is taken mod 2^ADDR_W anyway.
  assign offset = ADDR_W'(k) * ADDR_W'(FETCH_BEATS) + ADDR_W'(beat);
  assign a_addr = a_base + offset;
  assign b_addr = b_base + offset;

endmodule

// File: rtl/sp_tc_tile_sequencer.sv
// Runs one sparse tensor-core tile job as ksteps rounds of start/fetch/compute/write-back/result,
// with a watchdog on every wait for core status.
module sp_tc_tile_sequencer
  import sp_tc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int KSTEP_W     = 8,
  parameter int FETCH_BEATS = FETCH_BEATS_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [ADDR_W-1:0]  job_a_base,
  input  logic [ADDR_W-1:0]  job_b_base,
  input  logic [ADDR_W-1:0]  job_c_base,
  input  logic [KSTEP_W-1:0] job_ksteps,
  output logic               tc_start,
  output logic               tc_fetch_done,
  input  logic               tc_fetch,
  input  logic               tc_compute,
  input  logic               tc_write_back,
  output logic               ab_rd_en,
  output logic [ADDR_W-1:0]  a_rd_addr,
  output logic [ADDR_W-1:0]  b_rd_addr,
  output logic               c_rd_en,
  output logic [ADDR_W-1:0]  c_rd_addr,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ADDR_W-1:0]  res_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int WDOG_W = wdog_width(WDOG_CYCLES);
  localparam int BEAT_W = beat_width(FETCH_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  state_t             state;
  logic [ADDR_W-1:0]  a_base, b_base, c_base;
  logic [KSTEP_W-1:0] ksteps, k;
  logic [BEAT_W-1:0]  beat, beat_sel;
  logic [WDOG_W-1:0]  wdog;
  logic [ADDR_W-1:0]  a_next, b_next;
  logic               wdog_hit, last_k;

  // Address for the beat about to be issued: beat 0 when leaving WAIT_FETCH, beat+1 inside FETCH.
  assign beat_sel = (state == S_FETCH) ? beat + 1'b1 : '0;
  assign wdog_hit = (wdog == WDOG_LAST);
  assign last_k   = (k == ksteps - 1'b1);

  sp_tc_addr_gen #(
    .ADDR_W      (ADDR_W),
    .KSTEP_W     (KSTEP_W),
    .FETCH_BEATS (FETCH_BEATS),
    .BEAT_W      (BEAT_W)
  ) u_addr_gen (
    .a_base (a_base),
    .b_base (b_base),
    .k      (k),
    .beat   (beat_sel),
    .a_addr (a_next),
    .b_addr (b_next)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready; job_ready is high only in
  // IDLE, and res_valid/res_addr stay high and stable in RESULT until res_ready completes the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      job_ready     <= 1'b1;
      busy          <= 1'b0;
      tc_start      <= 1'b0;
      tc_fetch_done <= 1'b0;
      ab_rd_en      <= 1'b0;
      c_rd_en       <= 1'b0;
      a_rd_addr     <= '0;
      b_rd_addr     <= '0;
      c_rd_addr     <= '0;
      res_valid     <= 1'b0;
      res_addr      <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      a_base        <= '0;
      b_base        <= '0;
      c_base        <= '0;
      ksteps        <= '0;
      k             <= '0;
      beat          <= '0;
      wdog          <= '0;
    end else begin
      tc_start      <= 1'b0;
      tc_fetch_done <= 1'b0;
      ab_rd_en      <= 1'b0;
      c_rd_en       <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      wdog          <= '0;
      case (state)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            a_base <= job_a_base;
            b_base <= job_b_base;
            c_base <= job_c_base;
            ksteps <= job_ksteps;
            k      <= '0;
            if (job_ksteps == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_START;
              tc_start  <= 1'b1;
              job_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        S_START: state <= S_WAIT_FETCH;
        S_WAIT_FETCH: begin
          if (tc_fetch) begin
            state     <= S_FETCH;
            beat      <= '0;
            ab_rd_en  <= 1'b1;
            a_rd_addr <= a_next;
            b_rd_addr <= b_next;
            c_rd_en   <= 1'b1;
            c_rd_addr <= c_base;
          end else if (wdog_hit) begin
            state     <= S_IDLE;
            err       <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_FETCH: begin
          if (beat == LAST_BEAT) begin
            state         <= S_FDONE;
            tc_fetch_done <= 1'b1;
          end else begin
            beat      <= beat_sel;
            ab_rd_en  <= 1'b1;
            a_rd_addr <= a_next;
            b_rd_addr <= b_next;
          end
        end
        S_FDONE: state <= S_WAIT_COMP;
        S_WAIT_COMP: begin
          if (tc_compute) begin
            state <= S_WAIT_WB;
          end else if (wdog_hit) begin
            state     <= S_IDLE;
            err       <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_WAIT_WB: begin
          if (tc_write_back) begin
            state     <= S_RESULT;
            res_valid <= 1'b1;
            res_addr  <= c_base;
          end else if (wdog_hit) begin
            state     <= S_IDLE;
            err       <= 1'b1;
            job_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_k) begin
              state     <= S_IDLE;
              done      <= 1'b1;
              job_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              k        <= k + 1'b1;
              state    <= S_START;
              tc_start <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
